// File: rtl/counter_pkg.sv
// Shared types and elaboration checks for the parametrised up/down counter.
package counter_pkg;

   typedef enum logic {
      CNT_DOWN = 1'b0,
      CNT_UP   = 1'b1
   } cnt_dir_e;

   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_e;

   // The count range 0..modulus-1 must contain at least two values and fit in width bits.
   function automatic bit modulus_ok(input int width, input longint modulus);
      return (width >= 1) && (width <= 62) &&
             (modulus >= 2) && (modulus <= (longint'(1) << width));
   endfunction

   // A prescaler needs at least one enabled cycle per step.
   function automatic bit prescale_ok(input int prescale);
      return prescale >= 1;
   endfunction

endpackage

// File: rtl/updown_counter_if.sv
// Control and status bundle of the up/down counter.
interface updown_counter_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             up;
   logic             sat;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ovf;

   modport master (
      output en, up, sat, clear, load, load_value,
      input  count, tc, ovf
   );

   modport slave (
      input  en, up, sat, clear, load, load_value,
      output count, tc, ovf
   );
endinterface

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the last enabled cycle of each interval.
module counter_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic restart,
   output logic tick
);

   if (!prescale_ok(PRESCALE)) begin : g_bad_prescale
      $error("counter_prescaler: PRESCALE must be >= 1");
   end

   if (PRESCALE == 1) begin : g_direct
      // Every enabled cycle is a tick; there is no interval state to restart.
      logic unused_sig;
      assign unused_sig = clk ^ reset ^ restart;
      assign tick       = en;
   end else begin : g_div
      localparam int              PW   = $clog2(PRESCALE);
      localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] div_q;

      assign tick = en && (div_q == LAST);

      // Count enabled cycles, holding while en is low; restart begins a fresh interval.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            div_q <= '0;
         end else if (restart) begin
            div_q <= '0;
         end else if (en) begin
            if (div_q == LAST) div_q <= '0;
            else               div_q <= div_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with modulus, prescaler, wrap/saturate boundary and tc/ovf flags.
module updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MODULUS  = 256,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   updown_counter_if.slave  bus
);

   if (!modulus_ok(WIDTH, longint'(MODULUS))) begin : g_bad_modulus
      $error("updown_counter: MODULUS must be in 2..2**WIDTH");
   end

   if ($bits(bus.count) != WIDTH) begin : g_bad_bus
      $error("updown_counter: interface WIDTH does not match counter WIDTH");
   end

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

   logic             tick;
   logic             restart;
   logic             at_bound;
   cnt_dir_e         dir;
   cnt_mode_e        mode;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] stepped;
   logic [WIDTH-1:0] count_q;
   logic             tc_q;
   logic             ovf_q;

   assign restart = bus.clear | bus.load;

   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .en      (bus.en),
      .restart (restart),
      .tick    (tick)
   );

   // Next count for a tick, including the wrap/saturate handling at the range ends.
   always_comb begin
      dir          = cnt_dir_e'(bus.up);
      mode         = cnt_mode_e'(bus.sat);
      load_clamped = (bus.load_value > MAX_CNT) ? MAX_CNT : bus.load_value;
      at_bound     = (dir == CNT_UP) ? (count_q == MAX_CNT) : (count_q == '0);
      stepped      = count_q;
      if (at_bound) begin
         if (mode == CNT_WRAP) stepped = (dir == CNT_UP) ? '0 : MAX_CNT;
      end else begin
         stepped = (dir == CNT_UP) ? count_q + 1'b1 : count_q - 1'b1;
      end
   end

   // Count, terminal-count and sticky overflow registers; clear beats load beats step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (bus.clear) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (bus.load) begin
         count_q <= load_clamped;
         tc_q    <= 1'b0;
      end else begin
         tc_q <= tick && at_bound;
         if (tick) begin
            count_q <= stepped;
            if (at_bound) ovf_q <= 1'b1;
         end
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised up/down counter: the next generation of the team's fixed 8-bit free-running counter. Adds configurable width and modulus, count direction, an enable with a built-in prescaler, synchronous load/clear, wrap or saturate mode, and terminal-count and sticky overflow flags. Intended as the general timebase/event counter for the design, instantiated wherever a plain counter was used before.

## Interface
- WIDTH, 8: count register width in bits.
- MODULUS, 256: count range is 0..MODULUS-1. Elaboration error if MODULUS < 2 or MODULUS > 2**WIDTH.
- PRESCALE, 1: number of enabled cycles per count step. Elaboration error if < 1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  count enable; gates the prescaler and stepping.
- up  in  1  direction: 1 counts up, 0 counts down.
- sat  in  1  boundary mode: 0 wraps, 1 saturates.
- clear  in  1  synchronous clear of count, prescaler and ovf.
- load  in  1  synchronous load of load_value.
- load_value  in  WIDTH  value to load.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered.
- ovf  out  1  sticky boundary flag, registered.

## Operation
- Reset asserted (low): count=0, tc=0, ovf=0, prescaler=0, applied immediately and regardless of clk.
- Priority per edge: clear > load > step.
- clear: count=0, prescaler=0, ovf=0, tc=0.
- load: count = min(load_value, MODULUS-1), prescaler=0, tc=0. ovf is unchanged. No step occurs in the load cycle, even with en=1.
- Prescaler: counts enabled cycles 0..PRESCALE-1. It holds while en=0. A tick occurs when en=1 and the prescaler equals PRESCALE-1; the prescaler then returns to 0. With PRESCALE=1, every enabled cycle is a tick.
- Step on tick:
  - Up: count+1 if count < MODULUS-1.
  - Down: count-1 if count > 0.
- Boundary step (tick while up and count==MODULUS-1, or while down and count==0):
  - sat=0: count wraps to 0 (up) or to MODULUS-1 (down).
  - sat=1: count holds.
  - Either mode: tc=1 for that cycle and ovf is set.
- tc is 1 only in the cycle after a boundary step. It stays high on consecutive boundary steps, for example saturating with PRESCALE=1.
- ovf stays set until clear or reset.
- up and sat are sampled on each tick edge. Changing them between ticks has no other effect.

## Timing
- Count latency: 1 clk from the tick-qualifying edge to the updated count.
- Load and clear latency: 1 clk.
- tc and ovf update on the same edge as count.
- Outputs are purely registered; there is no combinational path from inputs to outputs.
- Reset deassertion is synchronous to clk at the system level; the block needs no internal synchroniser.
- Arithmetic is unsigned and WIDTH bits wide. The comparison against MODULUS-1 uses a WIDTH-bit localparam.

## Structure
- Package counter_pkg holds:
  - typedef for direction (CNT_DOWN=0, CNT_UP=1).
  - typedef for boundary mode (CNT_WRAP=0, CNT_SAT=1).
  - Shared elaboration-check helper for MODULUS and PRESCALE.
- Sub-module counter_prescaler(clk, reset, en, restart, tick):
  - Holds a $clog2(PRESCALE)-bit counter.
  - With PRESCALE=1 it degenerates to tick=en.
  - restart is driven by clear|load.
- Top level holds the count, tc and ovf registers and the boundary logic.

## Test plan
- Free-running count (WIDTH=8, MODULUS=256, PRESCALE=1, en=1, up=1, sat=0, 20 ns clock):
  - Reset low to high, then 256 edges.
  - Required: count runs 0x00..0xFF, then 0x00 with tc high for exactly 1 cycle; ovf=1 from then on.
- Modulus and direction (MODULUS=10):
  - Count up from 0: after 9 comes 0, with tc.
  - Set up=0 at count 0: next count is 9, with tc.
  - count never exceeds 9.
- Saturate (sat=1, MODULUS=256):
  - Load 0xFE, then count up: 0xFE, 0xFF, 0xFF, 0xFF; tc high on each held step; ovf=1.
  - Then up=0: count goes to 0xFE and tc=0.
- Priority and clamping:
  - clear and load together with load_value 0x2A: count=0x00 and ovf=0.
  - load 0x2A with en=1: count=0x2A next cycle, then 0x2B.
  - With MODULUS=10, load 0x2A: count=9.
- Prescaler (PRESCALE=4):
  - Count steps every 4th enabled cycle.
  - Drop en for 2 cycles mid-interval: the step is delayed by exactly 2 cycles.
  - load mid-interval restarts the 4-cycle interval.
- Asynchronous reset mid-operation:
  - Drive reset low between edges while count=0x37 and ovf=1.
  - Required: count=0, tc=0, ovf=0 before the next clk edge, held while reset is low.
  - Counting resumes from 0 after release.
